// File: rtl/macc_pkg.sv
// macc_pkg: shared types and helpers for the partial-product accumulator.
//   macc_state_t : IDLE / ACCUM / DONE controller states
//   SHIFT_SEL_W  : width of the shift_sel port
//   macc_cnt_w() : width of a term counter that can hold 0..num_terms
package macc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } macc_state_t;

  localparam int SHIFT_SEL_W = 2;

  // The counter must reach num_terms itself (it sits at that value in DONE).
  function automatic int macc_cnt_w(input int num_terms);
    return (num_terms < 1) ? 1 : $clog2(num_terms + 1);
  endfunction

endpackage

// File: rtl/macc_shift_add.sv
// macc_shift_add: combinational shift-and-add stage of the accumulator.
//   acc       in  WIDTH        current accumulator value
//   pp_in     in  IN_WIDTH     partial product (zero-extended)
//   shift_sel in  SHIFT_SEL_W  left shift = shift_sel*SHIFT_STEP
//   sum       out WIDTH        next accumulator value (wrapped or saturated)
//   ovf       out 1            addend lost nonzero bits or the add carried out
// SATURATE=1 replaces an overflowing sum with all-ones.
module macc_shift_add
  import macc_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int IN_WIDTH   = 8,
  parameter int SHIFT_STEP = 4,
  parameter bit SATURATE   = 1'b0
) (
  input  logic [WIDTH-1:0]       acc,
  input  logic [IN_WIDTH-1:0]    pp_in,
  input  logic [SHIFT_SEL_W-1:0] shift_sel,
  output logic [WIDTH-1:0]       sum,
  output logic                   ovf
);

  localparam int NUM_SH = 1 << SHIFT_SEL_W;
  localparam int MAX_SH = (NUM_SH - 1) * SHIFT_STEP;
  // Wide enough to hold the largest shifted product with no loss, and always
  // at least one bit above WIDTH so the truncation slice is never empty.
  localparam int EXT_W  = (((IN_WIDTH + MAX_SH) > WIDTH) ? (IN_WIDTH + MAX_SH) : WIDTH) + 1;

  logic [EXT_W-1:0] pp_ext;
  logic [EXT_W-1:0] sh_opt [NUM_SH];
  logic [EXT_W-1:0] shifted;
  logic             trunc;
  logic [WIDTH:0]   sum_full;

  assign pp_ext = EXT_W'(pp_in);

  // Constant shifts per select value; the mux below picks one.
  generate
    for (genvar gi = 0; gi < NUM_SH; gi++) begin : g_shift
      assign sh_opt[gi] = pp_ext << (gi * SHIFT_STEP);
    end
  endgenerate

  assign shifted  = sh_opt[shift_sel];
  assign trunc    = |shifted[EXT_W-1:WIDTH];
  assign sum_full = {1'b0, acc} + {1'b0, shifted[WIDTH-1:0]};
  assign ovf      = trunc | sum_full[WIDTH];

  generate
    if (SATURATE) begin : g_sat
      assign sum = ovf ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];
    end else begin : g_wrap
      assign sum = sum_full[WIDTH-1:0];
    end
  endgenerate

endmodule

// File: rtl/macc_accum_reg.sv
// macc_accum_reg: accumulates NUM_TERMS shifted partial products into a
// WIDTH-bit result register under an IDLE/ACCUM/DONE handshake.
//   clk        in  rising-edge clock
//   sclr       in  synchronous clear, wins over clk_ena
//   clk_ena    in  clock enable; 0 freezes all state
//   start      in  begin an operation (IDLE, or DONE together with done_ack)
//   pp_in      in  partial product
//   shift_sel  in  left shift = shift_sel*SHIFT_STEP
//   pp_valid   in  pp_in/shift_sel valid (used only in ACCUM)
//   done_ack   in  consumer takes the result (used only in DONE)
//   acc_out    out registered accumulator
//   busy       out state is ACCUM
//   done_valid out state is DONE
//   ovf        out sticky overflow for the current operation
// Build option: define MACC_SATURATE_EN to saturate at all-ones on overflow
// instead of wrapping modulo 2^WIDTH.
module macc_accum_reg
  import macc_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int IN_WIDTH   = 8,
  parameter int SHIFT_STEP = 4,
  parameter int NUM_TERMS  = 4
) (
  input  logic                   clk,
  input  logic                   sclr,
  input  logic                   clk_ena,
  input  logic                   start,
  input  logic [IN_WIDTH-1:0]    pp_in,
  input  logic [SHIFT_SEL_W-1:0] shift_sel,
  input  logic                   pp_valid,
  input  logic                   done_ack,
  output logic [WIDTH-1:0]       acc_out,
  output logic                   busy,
  output logic                   done_valid,
  output logic                   ovf
);

  localparam int               CNT_W    = macc_cnt_w(NUM_TERMS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

`ifdef MACC_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  macc_state_t      state_reg, state_next;
  logic [WIDTH-1:0] acc_reg,   acc_next;
  logic             ovf_reg,   ovf_next;
  logic [CNT_W-1:0] cnt_reg,   cnt_next;

  logic [WIDTH-1:0] add_sum;
  logic             add_ovf;

  macc_shift_add #(
    .WIDTH      (WIDTH),
    .IN_WIDTH   (IN_WIDTH),
    .SHIFT_STEP (SHIFT_STEP),
    .SATURATE   (SAT_EN)
  ) u_shift_add (
    .acc       (acc_reg),
    .pp_in     (pp_in),
    .shift_sel (shift_sel),
    .sum       (add_sum),
    .ovf       (add_ovf)
  );

  always_ff @(posedge clk) begin
    if (sclr) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      ovf_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else if (clk_ena) begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      ovf_reg   <= ovf_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    ovf_next   = ovf_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = ACCUM;
          acc_next   = '0;
          ovf_next   = 1'b0;
          cnt_next   = '0;
        end
      end
      ACCUM: begin
        if (pp_valid) begin
          acc_next = add_sum;
          ovf_next = ovf_reg | add_ovf;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == LAST_CNT) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (done_ack) begin
          if (start) begin
            // Back-to-back: skip IDLE so the next operation loses no cycle.
            state_next = ACCUM;
            acc_next   = '0;
            ovf_next   = 1'b0;
            cnt_next   = '0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign acc_out    = acc_reg;
  assign busy       = (state_reg == ACCUM);
  assign done_valid = (state_reg == DONE);
  assign ovf        = ovf_reg;

endmodule

// File: tb/tb_macc_accum_reg.sv
// tb_macc_accum_reg: drives a 16-bit and a 12-bit accumulator with the same
// stimulus and compares both against a cycle-level arithmetic model, plus
// directed checks on hand-computed results.
module tb_macc_accum_reg;

`ifdef MACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam int NT = 4;

  logic        clk = 1'b0;
  logic        sclr = 1'b0;
  logic        clk_ena = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  pp_in = '0;
  logic [1:0]  shift_sel = '0;
  logic        pp_valid = 1'b0;
  logic        done_ack = 1'b0;

  logic [15:0] acc16;
  logic        busy16, done16, ovf16;
  logic [11:0] acc12;
  logic        busy12, done12, ovf12;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;

  always #5 clk = ~clk;

  macc_accum_reg #(.WIDTH(16), .IN_WIDTH(8), .SHIFT_STEP(4), .NUM_TERMS(NT)) u_dut (
    .clk(clk), .sclr(sclr), .clk_ena(clk_ena), .start(start), .pp_in(pp_in),
    .shift_sel(shift_sel), .pp_valid(pp_valid), .done_ack(done_ack),
    .acc_out(acc16), .busy(busy16), .done_valid(done16), .ovf(ovf16)
  );

  macc_accum_reg #(.WIDTH(12), .IN_WIDTH(8), .SHIFT_STEP(4), .NUM_TERMS(NT)) u_dut12 (
    .clk(clk), .sclr(sclr), .clk_ena(clk_ena), .start(start), .pp_in(pp_in),
    .shift_sel(shift_sel), .pp_valid(pp_valid), .done_ack(done_ack),
    .acc_out(acc12), .busy(busy12), .done_valid(done12), .ovf(ovf12)
  );

  // Reference: phase 0=waiting, 1=collecting terms, 2=result held.
  typedef struct {
    int     phase;
    longint acc;
    bit     ovf;
    int     terms;
  } model_t;

  model_t m16, m12;

  function automatic model_t model_step(input model_t m, input int w, input bit s,
                                        input bit en, input bit st, input logic [7:0] pp,
                                        input logic [1:0] sel, input bit v, input bit ack);
    model_t n;
    longint lim;
    longint total;
    n = m;
    lim = longint'(1) << w;
    if (s) begin
      n.phase = 0; n.acc = 0; n.ovf = 0; n.terms = 0;
    end else if (en) begin
      if (m.phase == 0 && st) begin
        n.phase = 1; n.acc = 0; n.ovf = 0; n.terms = 0;
      end else if (m.phase == 1 && v) begin
        total = m.acc + longint'(pp) * (longint'(1) << (int'(sel) * 4));
        if (total >= lim) begin
          n.ovf = 1;
          n.acc = SAT ? (lim - 1) : (total % lim);
        end else begin
          n.acc = total;
        end
        n.terms = m.terms + 1;
        if (n.terms == NT) n.phase = 2;
      end else if (m.phase == 2 && ack) begin
        if (st) begin
          n.phase = 1; n.acc = 0; n.ovf = 0; n.terms = 0;
        end else begin
          n.phase = 0;
        end
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then
  // compare both DUTs 1 time unit after the edge.
  task automatic cyc();
    m16 = model_step(m16, 16, sclr, clk_ena, start, pp_in, shift_sel, pp_valid, done_ack);
    m12 = model_step(m12, 12, sclr, clk_ena, start, pp_in, shift_sel, pp_valid, done_ack);
    @(posedge clk);
    #1;
    cyc_n++;
    $display("cyc %0d sclr=%0b ena=%0b start=%0b v=%0b pp=%02h sel=%0d ack=%0b -> acc16=%04h busy=%0b done=%0b ovf=%0b acc12=%03h ovf12=%0b",
             cyc_n, sclr, clk_ena, start, pp_valid, pp_in, shift_sel, done_ack,
             acc16, busy16, done16, ovf16, acc12, ovf12);
    chk("acc16",  32'(acc16),  32'(m16.acc[15:0]));
    chk("busy16", 32'(busy16), 32'(m16.phase == 1));
    chk("done16", 32'(done16), 32'(m16.phase == 2));
    chk("ovf16",  32'(ovf16),  32'(m16.ovf));
    chk("acc12",  32'(acc12),  32'(m12.acc[11:0]));
    chk("busy12", 32'(busy12), 32'(m12.phase == 1));
    chk("done12", 32'(done12), 32'(m12.phase == 2));
    chk("ovf12",  32'(ovf12),  32'(m12.ovf));
  endtask

  task automatic term(input logic [7:0] p, input logic [1:0] s);
    pp_valid = 1'b1; pp_in = p; shift_sel = s;
    cyc();
    pp_valid = 1'b0; start = 1'b0;
  endtask

  initial begin
    m16 = '{phase: 0, acc: 0, ovf: 0, terms: 0};
    m12 = m16;

    // Reset state
    sclr = 1'b1; cyc(); sclr = 1'b0;
    chk("rst_acc", 32'(acc16), 32'h0);
    chk("rst_busy", 32'(busy16), 32'h0);
    chk("rst_done", 32'(done16), 32'h0);

    // 0xFF*0xFF via nibble partial products
    start = 1'b1; cyc(); start = 1'b0;
    chk("s1_busy", 32'(busy16), 32'h1);
    term(8'hE1, 2'd0); term(8'hE1, 2'd1); term(8'hE1, 2'd1);
    chk("s1_notdone", 32'(done16), 32'h0);
    term(8'hE1, 2'd2);
    chk("s1_acc", 32'(acc16), 32'hFE01);
    chk("s1_done", 32'(done16), 32'h1);
    chk("s1_ovf", 32'(ovf16), 32'h0);
    pp_valid = 1'b1; pp_in = 8'hFF; cyc(); pp_valid = 1'b0;  // ignored in DONE
    chk("s1_hold", 32'(acc16), 32'hFE01);
    done_ack = 1'b1; cyc(); done_ack = 1'b0;
    chk("s1_idle", 32'(done16), 32'h0);
    chk("s1_keep", 32'(acc16), 32'hFE01);

    // Overflow, plus truncation on the 12-bit instance
    start = 1'b1; cyc(); start = 1'b0;
    term(8'hFF, 2'd2);
    chk("trunc12_acc", 32'(acc12), SAT ? 32'hFFF : 32'hF00);
    chk("trunc12_ovf", 32'(ovf12), 32'h1);
    term(8'hFF, 2'd2); term(8'h00, 2'd0); term(8'h00, 2'd0);
    chk("ovf_acc", 32'(acc16), SAT ? 32'hFFFF : 32'hFE00);
    chk("ovf_flag", 32'(ovf16), 32'h1);

    // Back-to-back restart from DONE
    done_ack = 1'b1; start = 1'b1; cyc(); done_ack = 1'b0; start = 1'b0;
    chk("b2b_busy", 32'(busy16), 32'h1);
    chk("b2b_done", 32'(done16), 32'h0);
    chk("b2b_acc", 32'(acc16), 32'h0);
    chk("b2b_ovf", 32'(ovf16), 32'h0);

    // clk_ena gap after two terms; start during ACCUM must not restart
    term(8'hE1, 2'd0); term(8'hE1, 2'd1);
    clk_ena = 1'b0; pp_valid = 1'b1; pp_in = 8'hE1; shift_sel = 2'd1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("gap_acc", 32'(acc16), 32'h0EF1);
    end
    clk_ena = 1'b1; pp_valid = 1'b0;
    start = 1'b1; term(8'hE1, 2'd1);
    chk("nostart_acc", 32'(acc16), 32'h1D01);
    term(8'hE1, 2'd2);
    chk("gap_acc_final", 32'(acc16), 32'hFE01);
    chk("gap_done", 32'(done16), 32'h1);
    done_ack = 1'b1; cyc(); done_ack = 1'b0;

    // Reset wins over clk_ena=0 mid-operation
    start = 1'b1; cyc(); start = 1'b0;
    term(8'hE1, 2'd0);
    chk("pre_rst_acc", 32'(acc16), 32'h00E1);
    sclr = 1'b1; clk_ena = 1'b0; cyc(); sclr = 1'b0; clk_ena = 1'b1;
    chk("rst2_acc", 32'(acc16), 32'h0);
    chk("rst2_busy", 32'(busy16), 32'h0);
    chk("rst2_done", 32'(done16), 32'h0);
    chk("rst2_ovf", 32'(ovf16), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      sclr      = ($urandom_range(99) < 2);
      clk_ena   = ($urandom_range(99) < 85);
      start     = ($urandom_range(99) < 25);
      pp_valid  = ($urandom_range(99) < 65);
      done_ack  = ($urandom_range(99) < 35);
      pp_in     = 8'($urandom);
      shift_sel = 2'($urandom);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/macc_accum_reg.md
Name: macc_accum_reg

Overview:
- Parametrised successor to the team's fixed-width product register.
- Accumulates NUM_TERMS shifted partial products from the sequential multiplier datapath into a WIDTH-bit result register.
- Controlled by an IDLE/ACCUM/DONE state machine with start, per-term valid, and done/ack handshakes, plus a sticky overflow flag.
- Sits between the 4x4 partial-product multiplier and the product output.

Parameters:
WIDTH, 16, accumulator/result width
IN_WIDTH, 8, partial-product input width
SHIFT_STEP, 4, bit positions per shift_sel increment
NUM_TERMS, 4, partial products per operation (>=1)

Ports:
clk  input  1  rising-edge clock
sclr  input  1  synchronous active-high clear, independent of clk_ena
clk_ena  input  1  clock enable; when 0 all state holds
start  input  1  begin new accumulation
pp_in  input  IN_WIDTH  partial product
shift_sel  input  2  left-shift amount = shift_sel*SHIFT_STEP
pp_valid  input  1  pp_in/shift_sel valid this cycle
done_ack  input  1  consumer accepts result
acc_out  output  WIDTH  accumulator value (registered)
busy  output  1  high in ACCUM
done_valid  output  1  high in DONE
ovf  output  1  sticky overflow for the current operation

Behaviour:
- Reset: sclr=1 at a clk edge sets acc_out=0, ovf=0, term count=0, state=IDLE, busy=0, done_valid=0. This applies regardless of clk_ena.
- clk_ena=0 and sclr=0: every register holds; inputs are ignored.
- All rules below apply only when clk_ena=1 and sclr=0.
- IDLE:
  - acc_out holds the last result.
  - start=1 -> acc_out=0, ovf=0, count=0, state=ACCUM.
  - pp_valid is ignored.
- ACCUM:
  - pp_valid=1 -> addend = pp_in zero-extended, shifted left by shift_sel*SHIFT_STEP, truncated to WIDTH.
  - acc_out <= (acc_out + addend) mod 2^WIDTH.
  - ovf sets if any nonzero bit was truncated from the addend or the sum carries out of WIDTH. Once set, ovf stays 1 until the next start or sclr.
  - The count increments on each accepted term.
  - When the term accepted is number NUM_TERMS, state -> DONE.
  - start is ignored in ACCUM.
  - shift_sel=3 is legal; its truncation counts toward ovf.
- DONE:
  - done_valid=1; acc_out and ovf are stable.
  - done_ack=1 -> IDLE.
  - done_ack=1 and start=1 together -> ACCUM directly; acc_out cleared, ovf cleared.
  - pp_valid is ignored.
- Latency: acc_out reflects an accepted term one cycle after acceptance. done_valid rises the cycle after the final term.
- Minimum operation: start plus NUM_TERMS accepted terms = NUM_TERMS+1 cycles to DONE.
- Reset mid-operation: sclr aborts to IDLE with all outputs zero; the partial result is discarded.

Optional Feature:
- Macro: MACC_SATURATE_EN.
- Defined: an overflowing accumulate loads all-ones (2^WIDTH-1) instead of the wrapped sum. Once saturated, acc_out remains all-ones until start or sclr. ovf is still set.
- Undefined: modulo-2^WIDTH wrap as above.

Decomposition:
- Shared package macc_pkg holds:
  - state enum type macc_state_t {IDLE, ACCUM, DONE}
  - shift_sel width constant SHIFT_SEL_W=2
  - helper function for count width, $clog2(NUM_TERMS+1)
- One natural sub-module: macc_shift_add, combinational. It takes acc, pp_in, shift_sel and the saturate option, and returns the next sum plus an overflow bit. The FSM, counter and registers stay in the top.

Test Plan:
- 0xFF*0xFF via nibbles, defaults. Sequence: start; then terms (0xE1,sel0), (0xE1,sel1), (0xE1,sel1), (0xE1,sel2). Expected: acc_out=0xFE01 and done_valid=1 on the cycle after the 4th term; ovf=0.
- Overflow. Terms (0xFF,sel2) x2 then (0x00,sel0) x2. Expected: acc_out=0xFE00 with ovf=1 when wrapping; acc_out=0xFFFF with ovf=1 when MACC_SATURATE_EN is defined.
- clk_ena gap. Drop clk_ena to 0 for 3 cycles after term 2 while pp_valid=1. Expected: acc_out and count unchanged during the gap; the final result is the same as the first scenario.
- Reset precedence. Assert sclr=1 with clk_ena=0 mid-ACCUM (acc_out=0x0E1). Expected next cycle: acc_out=0, busy=0, done_valid=0, ovf=0.
- Back-to-back. In DONE, assert done_ack=1 and start=1 together. Expected next cycle: busy=1, done_valid=0, acc_out=0. Also check that start asserted during ACCUM does not restart.
- Truncation. Set WIDTH=12 and apply term (0xFF,sel2). Expected: acc_out=0xF00 and ovf=1.
